// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the CLArbiter request path. Holds the default sizes
// used by req_fifo_bank, req_fifo and the arbiter itself, plus the common
// payload and requester-index types so that every block agrees on widths.
//
// Contents:
//   NUM_REQ_DEF  default number of requesters
//   DATA_W_DEF   default payload width per queued entry
//   DEPTH_DEF    default entries per requester FIFO (power of two, >= 2)
//   SRC_W_DEF    width of a requester index at the default size
//   src_idx_t    requester index type
//   payload_t    queued payload type
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int SRC_W_DEF   = $clog2(NUM_REQ_DEF);

  typedef logic [SRC_W_DEF-1:0]  src_idx_t;
  typedef logic [DATA_W_DEF-1:0] payload_t;

endpackage

// File: rtl/req_fifo.sv
// ---------------------------------------------------------------------------
// req_fifo
// One requester's queue: a circular buffer with read/write pointers that
// wrap modulo Depth and an occupancy count one bit wider than the pointers.
//
// Ports:
//   clk         rising-edge clock
//   rstN        asynchronous active-low reset (clears pointers and count)
//   push_valid  write strobe; accepted only while the FIFO is not full
//   push_data   write payload
//   pop         remove the head entry; ignored while the FIFO is empty
//   full        count == Depth
//   empty       count == 0
//   head_data   entry at the read pointer (meaningless while empty)
// ---------------------------------------------------------------------------
module req_fifo
  import cla_pkg::*;
#(
  parameter int DataW = DATA_W_DEF,
  parameter int Depth = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push_valid,
  input  logic [DataW-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [DataW-1:0] head_data
);

  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = AddrW + 1;

  logic [DataW-1:0] mem [Depth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [CntW-1:0]  count;
  logic             push_en;
  logic             pop_en;

  assign full      = (count == CntW'(Depth));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Fullness is judged on the registered count, so a push to a full FIFO is
  // dropped even when the head is popped on the same edge.
  assign push_en = push_valid && !full;
  assign pop_en  = pop && !empty;

  // Storage carries no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers rely on natural wrap because Depth is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AddrW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/req_fifo_bank.sv
// ---------------------------------------------------------------------------
// req_fifo_bank
// A bank of NumReq independent request FIFOs feeding a one-hot arbiter.
// Each non-empty FIFO raises its req_out bit; the arbiter answers with
// grant_in and the granted head is popped on that same edge, appearing on
// out_valid/out_data/out_src one cycle later. Malformed grants (multi-hot or
// aimed at an empty FIFO) pop nothing and latch err_out until reset.
//
// Ports:
//   clk         rising-edge clock
//   rstN        asynchronous active-low reset
//   push_valid  [NumReq]        per-requester write strobe
//   push_data   [NumReq*DataW]  per-requester payload, requester i in slice i
//   push_ready  [NumReq]        per-requester FIFO not full
//   req_out     [NumReq]        per-requester FIFO non-empty
//   grant_in    [NumReq]        one-hot grant from the arbiter
//   out_valid                   an entry was popped on the previous edge
//   out_data    [DataW]         payload of the popped entry
//   out_src     [$clog2(NumReq)] requester the entry came from
//   err_out                     sticky grant-protocol error
// ---------------------------------------------------------------------------
module req_fifo_bank
  import cla_pkg::*;
#(
  parameter int NumReq = NUM_REQ_DEF,
  parameter int DataW  = DATA_W_DEF,
  parameter int Depth  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [NumReq-1:0]          push_valid,
  input  logic [NumReq*DataW-1:0]    push_data,
  output logic [NumReq-1:0]          push_ready,
  output logic [NumReq-1:0]          req_out,
  input  logic [NumReq-1:0]          grant_in,
  output logic                       out_valid,
  output logic [DataW-1:0]           out_data,
  output logic [$clog2(NumReq)-1:0]  out_src,
  output logic                       err_out
);

  localparam int SrcW = $clog2(NumReq);

  logic [NumReq-1:0] fifo_full;
  logic [NumReq-1:0] fifo_empty;
  logic [DataW-1:0]  head_data [NumReq];
  logic [NumReq-1:0] pop_vec;

  logic              grant_one_hot;
  logic              grant_legal;
  logic              grant_illegal;
  logic [DataW-1:0]  sel_data;
  logic [SrcW-1:0]   sel_src;

  // Both flags come straight from registered counts inside each FIFO, so
  // there is no combinational path from push_valid to req_out.
  assign push_ready = ~fifo_full;
  assign req_out    = ~fifo_empty;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_fifo
      req_fifo #(
        .DataW (DataW),
        .Depth (Depth)
      ) u_fifo (
        .clk        (clk),
        .rstN       (rstN),
        .push_valid (push_valid[gi]),
        .push_data  (push_data[gi*DataW +: DataW]),
        .pop        (pop_vec[gi]),
        .full       (fifo_full[gi]),
        .empty      (fifo_empty[gi]),
        .head_data  (head_data[gi])
      );
    end
  endgenerate

  // A grant is legal only when exactly one bit is set and that requester
  // actually has something queued; anything else non-zero is an error.
  assign grant_one_hot = (grant_in != '0) &&
                         ((grant_in & (grant_in - NumReq'(1))) == '0);
  assign grant_legal   = grant_one_hot && ((grant_in & req_out) != '0);
  assign grant_illegal = (grant_in != '0) && !grant_legal;
  assign pop_vec       = grant_legal ? grant_in : '0;

  // Head-of-line select keyed off the grant bits; only consumed when the
  // grant is legal, so the multi-hot result is never used.
  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_in[i]) begin
        sel_data = head_data[i];
        sel_src  = SrcW'(i);
      end
    end
  end

  // Output register: data/source only update on a real pop so they hold
  // the last delivered entry while out_valid is low.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      out_valid <= grant_legal;
      if (grant_legal) begin
        out_data <= sel_data;
        out_src  <= sel_src;
      end
    end
  end

  // Error flag is sticky; only reset clears it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      err_out <= 1'b0;
    end else if (grant_illegal) begin
      err_out <= 1'b1;
    end
  end

endmodule

// File: doc/req_fifo_bank.md
REQ_FIFO_BANK -- requirements
Module: req_fifo_bank

Interface
REQ-001 Parameter NumReq, default 3: number of requesters, equal to the CLArbiter NumReq.
REQ-002 Parameter DataW, default 8: payload width per entry.
REQ-003 Parameter Depth, default 4: entries per requester FIFO; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstN  input  1  reset, asynchronous and active-low.
REQ-006 push_valid  input  NumReq  per-requester write strobe.
REQ-007 push_data  input  NumReq x DataW  per-requester write payload.
REQ-008 push_ready  output  NumReq  per-requester FIFO not full.
REQ-009 req_out  output  NumReq  per-requester FIFO non-empty; drives CLArbiter req_in.
REQ-010 grant_in  input  NumReq  one-hot grant from CLArbiter grant_out.
REQ-011 out_valid  output  1  registered strobe: one entry popped last cycle.
REQ-012 out_data  output  DataW  payload of the popped entry.
REQ-013 out_src  output  $clog2(NumReq)  index of the requester that was popped.
REQ-014 err_out  output  1  sticky grant-protocol error flag.

Function
REQ-015 Per-requester FIFO i: push when push_valid[i] and push_ready[i]; push_ready[i] = count[i] < Depth.
REQ-016 A push to a full FIFO is dropped, and the FIFO state is unchanged, even if a pop of that FIFO occurs in the same cycle.
REQ-017 req_out[i] = count[i] != 0, driven from registered count only, with no combinational path from push_valid.
REQ-018 A push into an empty FIFO raises req_out[i] on the cycle after the push edge.
REQ-019 Legal grant: grant_in is one-hot and req_out is set for the granted bit. It pops the head of that FIFO at the same edge.
REQ-020 Pop latency is 1 cycle: on the edge after a legal grant, out_valid=1, out_data=head entry, out_src=i. Otherwise out_valid=0 and out_data/out_src hold their previous values.
REQ-021 Illegal grant: a multi-hot grant, or a grant to an empty FIFO. It causes no pop in any FIFO and sets err_out at the next edge. err_out stays set until reset.
REQ-022 An all-zero grant_in is idle: no pop and no error.
REQ-023 Simultaneous push and pop on the same non-full, non-empty FIFO: both happen and the count is unchanged.
REQ-024 Simultaneous push and pop on an empty FIFO: the pop is illegal per REQ-021, and the push is accepted.
REQ-025 Read and write pointers are $clog2(Depth) bits and wrap modulo Depth. The count is $clog2(Depth)+1 bits.
REQ-026 Entries leave each FIFO in strict FIFO order. FIFOs are independent of each other.

Reset
REQ-027 While rstN=0, all counts and pointers are 0, push_ready is all ones, req_out=0, out_valid=0, out_data=0, out_src=0 and err_out=0.
REQ-028 Reset asserted mid-operation discards all stored entries immediately, without waiting for a clock edge.
REQ-029 Storage array contents need no reset. They are never observable while the FIFO is empty.

Structure
REQ-030 Shared package cla_pkg holds the following: NumReq, DataW and Depth defaults; src index typedef; payload typedef. CLArbiter and its bench import it.
REQ-031 One sub-module, req_fifo: single FIFO with push/pop/count/full/empty. It is instantiated NumReq times via generate.
REQ-032 The pop-select and output register logic live in req_fifo_bank, not in req_fifo.

Verification
REQ-033 Reset, then push 0x11 to requester 0 -> req_out=3'b001 on the next cycle. grant_in=3'b001 -> out_valid=1, out_data=0x11, out_src=0 one cycle later, and req_out returns to 3'b000.
REQ-034 Push 0xA0..0xA3 to requester 2 -> push_ready[2]=0. Push 0xA4 -> dropped. Four grants 3'b100 -> out_data sequence A0, A1, A2, A3.
REQ-035 Connect to CLArbiter and load requesters 0, 1, 2 with 2 entries each -> all 6 entries appear exactly once, and out_src matches the arbiter grant order.
REQ-036 grant_in=3'b011 with both FIFOs non-empty -> no count change, err_out=1, which persists until rstN=0.
REQ-037 grant_in=3'b010 while FIFO 1 is empty -> err_out=1 and out_valid=0.
REQ-038 Fill FIFO 0 with 3 entries, pulse rstN low between edges -> req_out=0 and push_ready=3'b111 immediately. A subsequent grant 3'b001 sets err_out.
